// File: rtl/sd_spi_pkg.sv
// Shared constants and types for the SD SPI-mode responder and its card model.
package sd_spi_pkg;
  localparam logic [6:0] CRC7_POLY = 7'h09;
  localparam logic [1:0] CMD_START = 2'b01;
  localparam logic [7:0] IDLE_FILL = 8'hFF;
  localparam int         CMD_BYTES = 6;

  typedef enum logic {IDLE, COLLECT} frm_state_e;

  typedef struct packed {
    logic [5:0]  index;
    logic [31:0] arg;
    logic        crc_ok;
  } cmd_t;
endpackage

// File: rtl/sd_crc7.sv
// One byte of SD CRC7 (x^7+x^3+1), MSB first, purely combinational.
module sd_crc7
  import sd_spi_pkg::*;
(
  input  logic [6:0] crc_i,
  input  logic [7:0] byte_i,
  output logic [6:0] crc_o
);
  always_comb begin
    logic [6:0] c;
    logic       fb;
    c  = crc_i;
    fb = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      fb = c[6] ^ byte_i[i];
      c  = {c[5:0], 1'b0};
      if (fb) c = c ^ CRC7_POLY;
    end
    crc_o = c;
  end
endmodule

// File: rtl/sd_spi_responder.sv
// SPI mode-0 card-side responder: byte shifter, SD command framer and MISO TX FIFO.
module sd_spi_responder
  import sd_spi_pkg::*;
#(
  parameter int TX_DEPTH  = 8,
  parameter bit CHECK_CRC = 1'b1
) (
  input  logic                      clk,
  input  logic                      nRESET,
  input  logic                      spi_cs,
  input  logic                      spi_sck,
  input  logic                      spi_di,
  output logic                      spi_do,
  output logic [7:0]                rx_byte,
  output logic                      rx_strobe,
  output logic                      cmd_valid,
  output logic [5:0]                cmd_index,
  output logic [31:0]               cmd_arg,
  output logic                      cmd_crc_ok,
  input  logic [7:0]                tx_data,
  input  logic                      tx_write,
  input  logic                      tx_flush,
  output logic                      tx_full,
  output logic [$clog2(TX_DEPTH):0] tx_level
);
  localparam int AW = $clog2(TX_DEPTH);
  localparam int LW = AW + 1;

  logic          sck_q, cs_q;
  logic [2:0]    bit_cnt_q;
  logic [6:0]    in_q;
  logic [7:0]    out_q, rx_byte_q;
  logic          rx_strobe_q;
  logic          rise, fall, cs_fall, byte_done, load, push, pop, empty;

  logic [7:0]    mem_q [TX_DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [LW-1:0] level_q;

  assign rise      = ~spi_cs & spi_sck & ~sck_q;
  assign fall      = ~spi_cs & ~spi_sck & sck_q;
  assign cs_fall   = ~spi_cs & cs_q;
  assign byte_done = rise & (bit_cnt_q == 3'd7);
  assign load      = cs_fall | byte_done;
  assign empty     = (level_q == '0);
  assign tx_full   = (level_q == LW'(TX_DEPTH));
  assign push      = tx_write & ~tx_full;
  assign pop       = load & ~empty;

  always_ff @(posedge clk or negedge nRESET) begin
    if (!nRESET) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else if (tx_flush) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + AW'(1);
      if (pop)  rptr_q <= rptr_q + AW'(1);
      level_q <= level_q + LW'(push) - LW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !tx_flush) mem_q[wptr_q] <= tx_data;
  end

  always_ff @(posedge clk or negedge nRESET) begin
    if (!nRESET) begin
      sck_q       <= 1'b0;
      cs_q        <= 1'b1;
      bit_cnt_q   <= '0;
      in_q        <= '0;
      out_q       <= IDLE_FILL;
      rx_byte_q   <= '0;
      rx_strobe_q <= 1'b0;
    end else begin
      sck_q       <= spi_sck;
      cs_q        <= spi_cs;
      rx_strobe_q <= byte_done;
      if (spi_cs) begin
        bit_cnt_q <= '0;
        in_q      <= '0;
        out_q     <= IDLE_FILL;
      end else begin
        if (rise) begin
          in_q      <= {in_q[5:0], spi_di};
          bit_cnt_q <= bit_cnt_q + 3'd1;
        end
        if (byte_done) rx_byte_q <= {in_q, spi_di};
        // The fall right after a byte-completing rise must not shift out the
        // freshly loaded MSB, so only falls inside a byte shift.
        if (load)                          out_q <= pop ? mem_q[rptr_q] : IDLE_FILL;
        else if (fall && bit_cnt_q != '0)  out_q <= {out_q[6:0], 1'b1};
      end
    end
  end

  frm_state_e  state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [6:0]  crc_q, crc_d, crc_next;
  logic [5:0]  idx_q, idx_d;
  logic [31:0] arg_q, arg_d;
  cmd_t        cmd_q, cmd_d;
  logic        cmd_valid_q, cmd_valid_d, crc_match;

  sd_crc7 u_crc (
    .crc_i  ((state_q == IDLE) ? 7'h00 : crc_q),
    .byte_i (rx_byte_q),
    .crc_o  (crc_next)
  );

  assign crc_match = CHECK_CRC ? ((rx_byte_q[7:1] == crc_q) && rx_byte_q[0]) : 1'b1;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    crc_d       = crc_q;
    idx_d       = idx_q;
    arg_d       = arg_q;
    cmd_d       = cmd_q;
    cmd_valid_d = 1'b0;
    if (spi_cs) begin
      state_d = IDLE;
    end else if (rx_strobe_q) begin
      case (state_q)
        IDLE: if (rx_byte_q[7:6] == CMD_START) begin
          state_d = COLLECT;
          idx_d   = rx_byte_q[5:0];
          cnt_d   = 3'd1;
          crc_d   = crc_next;
        end
        COLLECT: if (cnt_q == 3'(CMD_BYTES - 1)) begin
          state_d     = IDLE;
          cmd_valid_d = 1'b1;
          cmd_d       = '{index: idx_q, arg: arg_q, crc_ok: crc_match};
        end else begin
          arg_d = {arg_q[23:0], rx_byte_q};
          crc_d = crc_next;
          cnt_d = cnt_q + 3'd1;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge nRESET) begin
    if (!nRESET) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      crc_q       <= '0;
      idx_q       <= '0;
      arg_q       <= '0;
      cmd_q       <= '0;
      cmd_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      crc_q       <= crc_d;
      idx_q       <= idx_d;
      arg_q       <= arg_d;
      cmd_q       <= cmd_d;
      cmd_valid_q <= cmd_valid_d;
    end
  end

  assign spi_do     = out_q[7];
  assign rx_byte    = rx_byte_q;
  assign rx_strobe  = rx_strobe_q;
  assign cmd_valid  = cmd_valid_q;
  assign cmd_index  = cmd_q.index;
  assign cmd_arg    = cmd_q.arg;
  assign cmd_crc_ok = cmd_q.crc_ok;
  assign tx_level   = level_q;
endmodule

// File: tb/tb_sd_spi_responder.sv
// Scoreboarded bench: stimulus queues expected RX bytes, MISO bytes and commands; monitors compare.
module tb_sd_spi_responder;
  import sd_spi_pkg::*;

  logic        clk = 1'b0, nRESET = 1'b0;
  logic        spi_cs = 1'b1, spi_sck = 1'b0, spi_di = 1'b0;
  logic [7:0]  tx_data = 8'h00;
  logic        tx_write = 1'b0, tx_flush = 1'b0;

  logic        spi_do, rx_strobe, cmd_valid, cmd_crc_ok, tx_full;
  logic [7:0]  rx_byte;
  logic [5:0]  cmd_index;
  logic [31:0] cmd_arg;
  logic [3:0]  tx_level;

  logic        spi_do0, rx_strobe0, cmd_valid0, cmd_crc_ok0, tx_full0;
  logic [7:0]  rx_byte0;
  logic [5:0]  cmd_index0;
  logic [31:0] cmd_arg0;
  logic [3:0]  tx_level0;

  sd_spi_responder #(.TX_DEPTH(8), .CHECK_CRC(1'b1)) dut (
    .clk(clk), .nRESET(nRESET), .spi_cs(spi_cs), .spi_sck(spi_sck), .spi_di(spi_di),
    .spi_do(spi_do), .rx_byte(rx_byte), .rx_strobe(rx_strobe), .cmd_valid(cmd_valid),
    .cmd_index(cmd_index), .cmd_arg(cmd_arg), .cmd_crc_ok(cmd_crc_ok),
    .tx_data(tx_data), .tx_write(tx_write), .tx_flush(tx_flush),
    .tx_full(tx_full), .tx_level(tx_level));

  sd_spi_responder #(.TX_DEPTH(8), .CHECK_CRC(1'b0)) dut0 (
    .clk(clk), .nRESET(nRESET), .spi_cs(spi_cs), .spi_sck(spi_sck), .spi_di(spi_di),
    .spi_do(spi_do0), .rx_byte(rx_byte0), .rx_strobe(rx_strobe0), .cmd_valid(cmd_valid0),
    .cmd_index(cmd_index0), .cmd_arg(cmd_arg0), .cmd_crc_ok(cmd_crc_ok0),
    .tx_data(tx_data), .tx_write(tx_write), .tx_flush(tx_flush),
    .tx_full(tx_full0), .tx_level(tx_level0));

  always #5 clk = ~clk;

  int npass = 0, ntot = 0;
  logic [7:0] exp_rx[$];
  logic [7:0] exp_miso[$];
  cmd_t       exp_cmd[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic unexp(input string name, input logic [63:0] act);
    ntot++;
    $display("FAIL %s: got %0h with nothing expected", name, act);
  endtask

  // Monitor: samples at negedge, between the TB driving (posedge+1) and the DUT reacting.
  logic       psck = 1'b0, pstrobe = 1'b0;
  logic [7:0] msh = 8'h00;
  int         mcnt = 0;
  initial forever begin
    @(negedge clk);
    if (!nRESET || spi_cs) mcnt = 0;
    else if (spi_sck && !psck) begin
      msh = {msh[6:0], spi_do};
      mcnt++;
      if (mcnt == 8) begin
        mcnt = 0;
        if (exp_miso.size() == 0) unexp("miso", msh);
        else chk("miso", msh, exp_miso.pop_front());
      end
    end
    psck = spi_sck;
    if (rx_strobe) begin
      if (exp_rx.size() == 0) unexp("rx_byte", rx_byte);
      else chk("rx_byte", rx_byte, exp_rx.pop_front());
    end
    if (cmd_valid) begin
      chk("cmd_latency", pstrobe, 1'b1);
      chk("crc_off", {cmd_valid0, cmd_crc_ok0}, 2'b11);
      if (exp_cmd.size() == 0) unexp("cmd", {cmd_index, cmd_arg, cmd_crc_ok});
      else chk("cmd", {cmd_index, cmd_arg, cmd_crc_ok}, exp_cmd.pop_front());
    end
    pstrobe = rx_strobe;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic spi_bits(input int n, input logic [7:0] b);
    for (int i = 7; i > 7 - n; i--) begin
      spi_di = b[i];
      tick(2);
      spi_sck = 1'b1;
      tick(2);
      spi_sck = 1'b0;
    end
    tick(2);
  endtask

  task automatic spi_byte(input logic [7:0] mosi, input logic [7:0] miso);
    exp_rx.push_back(mosi);
    exp_miso.push_back(miso);
    spi_bits(8, mosi);
  endtask

  task automatic send_frame(input logic [47:0] f, input bit has_cmd, input cmd_t c);
    if (has_cmd) exp_cmd.push_back(c);
    for (int i = 5; i >= 0; i--) spi_byte(f[i*8 +: 8], 8'hFF);
  endtask

  task automatic push(input logic [7:0] b);
    tx_data  = b;
    tx_write = 1'b1;
    tick(1);
    tx_write = 1'b0;
  endtask

  task automatic cs_low();  spi_cs = 1'b0; tick(3); endtask
  task automatic cs_high(); spi_cs = 1'b1; tick(3); endtask

  initial begin
    tick(3);
    chk("reset_state", {spi_do, rx_byte, rx_strobe, cmd_valid, cmd_index, cmd_arg,
                        cmd_crc_ok, tx_full, tx_level}, {1'b1, 54'h0});
    nRESET = 1'b1;
    tick(2);

    // Empty FIFO sends idle fill, then queued bytes in order.
    cs_low();
    spi_byte(8'hFF, 8'hFF);
    spi_byte(8'hFF, 8'hFF);
    cs_high();
    push(8'h01);
    push(8'hFE);
    chk("level_2", tx_level, 4'd2);
    cs_low();
    spi_byte(8'hFF, 8'h01);
    spi_byte(8'hFF, 8'hFE);
    spi_byte(8'hFF, 8'hFF);
    chk("level_drained", tx_level, 4'd0);
    cs_high();

    // CMD0, CMD8 good CRC, CMD8 bad CRC (CHECK_CRC=0 instance still reports ok).
    cs_low();
    send_frame(48'h40_00000000_95, 1'b1, '{index: 6'd0, arg: 32'h0, crc_ok: 1'b1});
    send_frame(48'h48_000001AA_87, 1'b1, '{index: 6'd8, arg: 32'h1AA, crc_ok: 1'b1});
    send_frame(48'h48_000001AA_86, 1'b1, '{index: 6'd8, arg: 32'h1AA, crc_ok: 1'b0});
    cs_high();

    // Overfill: ninth byte dropped.
    for (int i = 0; i < 8; i++) push(8'h11 + 8'(i));
    chk("full_at_8", {tx_full, tx_level}, {1'b1, 4'd8});
    push(8'h19);
    chk("drop_when_full", {tx_full, tx_level}, {1'b1, 4'd8});
    cs_low();
    for (int i = 0; i < 8; i++) spi_byte(8'hFF, 8'h11 + 8'(i));
    spi_byte(8'hFF, 8'hFF);
    chk("empty_after_drain", {tx_full, tx_level}, {1'b0, 4'd0});
    cs_high();

    // Flush mid-stream: the byte already in the shifter still goes out.
    for (int i = 0; i < 4; i++) push(8'hA1 + 8'(i));
    cs_low();
    chk("level_after_csfall", tx_level, 4'd3);
    spi_byte(8'hFF, 8'hA1);
    tx_flush = 1'b1;
    tick(1);
    tx_flush = 1'b0;
    chk("flush_level", tx_level, 4'd0);
    spi_byte(8'hFF, 8'hA2);
    spi_byte(8'hFF, 8'hFF);
    cs_high();

    // CS abort after 3 bits, then realigned CMD0.
    cs_low();
    spi_bits(3, 8'h40);
    cs_high();
    cs_low();
    send_frame(48'h40_00000000_95, 1'b1, '{index: 6'd0, arg: 32'h0, crc_ok: 1'b1});
    cs_high();

    // CS abort after 3 frame bytes: no command, framer restarts cleanly.
    cs_low();
    spi_byte(8'h40, 8'hFF);
    spi_byte(8'h00, 8'hFF);
    spi_byte(8'h00, 8'hFF);
    cs_high();
    cs_low();
    send_frame(48'h48_000001AA_87, 1'b1, '{index: 6'd8, arg: 32'h1AA, crc_ok: 1'b1});
    cs_high();

    // Asynchronous reset mid-frame with FIFO data pending.
    for (int i = 0; i < 4; i++) push(8'hC1 + 8'(i));
    cs_low();
    spi_byte(8'h48, 8'hC1);
    spi_byte(8'h5A, 8'hC2);
    spi_bits(3, 8'hFF);
    nRESET = 1'b0;
    #1;
    chk("async_reset", {spi_do, rx_byte, rx_strobe, cmd_valid, cmd_index, cmd_arg,
                        cmd_crc_ok, tx_full, tx_level}, {1'b1, 54'h0});
    spi_cs = 1'b1;
    tick(2);
    nRESET = 1'b1;
    tick(2);
    cs_low();
    send_frame(48'h40_00000000_95, 1'b1, '{index: 6'd0, arg: 32'h0, crc_ok: 1'b1});
    cs_high();

    for (int i = 0; i < 200 && (exp_rx.size() + exp_miso.size() + exp_cmd.size()) != 0; i++)
      tick(1);
    chk("rx_drained", exp_rx.size(), 0);
    chk("miso_drained", exp_miso.size(), 0);
    chk("cmd_drained", exp_cmd.size(), 0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
